bypass_select_ctrl: RTL and testbench

- Generates the per-operand bypass select (stage + lane) consumed by the backend bypass network.
- Tracks destination physical-register tags of in-flight producers through a shadow pipeline: INT EX→WB and MEM MA→WB. This pipeline moves in lockstep with the backend stall/clear controls.
- Each consumer source tag is compared against all tracked producers; the youngest matching producer is selected.
- Sits beside the register-read stage. It also keeps a saturating bypass-hit performance counter.

---
 rtl/bypass_select_ctrl.sv | 115 +++++++++++
 tb/tb_bypass_select_ctrl.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bypass_select_ctrl.sv
// Per-operand bypass select from a shadow producer pipeline (INT EX->WB, MEM MA->WB); select is combinational.
// Producers appear one cycle after presentation and leave after WB; stall holds all state, clear drops producers.
module bypass_select_ctrl #(
   parameter int INT_LANES = 2,
   parameter int MEM_LANES = 2,
   parameter int CONSUMERS = 6,
   parameter int PREG_W    = 7,
   parameter int LANE_W    = 1,
   parameter int CNT_W     = 32
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          stall,
   input  logic                          clear,
   input  logic [INT_LANES-1:0]          int_dst_valid,
   input  logic [INT_LANES*PREG_W-1:0]   int_dst_preg,
   input  logic [MEM_LANES-1:0]          mem_dst_valid,
   input  logic [MEM_LANES*PREG_W-1:0]   mem_dst_preg,
   input  logic [CONSUMERS-1:0]          src_valid,
   input  logic [CONSUMERS*PREG_W-1:0]   src_preg,
   output logic [CONSUMERS-1:0]          sel_hit,
   output logic [CONSUMERS*2-1:0]        sel_stg,
   output logic [CONSUMERS*LANE_W-1:0]   sel_lane,
   output logic [CNT_W-1:0]              hit_count
);

   localparam logic [1:0] STG_INT_EX = 2'd0;
   localparam logic [1:0] STG_INT_WB = 2'd1;
   localparam logic [1:0] STG_MEM_MA = 2'd2;
   localparam logic [1:0] STG_MEM_WB = 2'd3;

   logic [INT_LANES-1:0]             iex_v, iwb_v;
   logic [INT_LANES-1:0][PREG_W-1:0] iex_t, iwb_t;
   logic [MEM_LANES-1:0]             mma_v, mwb_v;
   logic [MEM_LANES-1:0][PREG_W-1:0] mma_t, mwb_t;
   logic [PREG_W-1:0]                src_tag;
   logic [CNT_W:0]                   hit_sum;

   // Tags need no reset: they are only ever qualified by their valid bit.
   always_ff @(posedge clk) begin
      if (rst || clear) begin
         iex_v <= '0;
         iwb_v <= '0;
         mma_v <= '0;
         mwb_v <= '0;
      end else if (!stall) begin
         iex_v <= int_dst_valid;
         iex_t <= int_dst_preg;
         iwb_v <= iex_v;
         iwb_t <= iex_t;
         mma_v <= mem_dst_valid;
         mma_t <= mem_dst_preg;
         mwb_v <= mma_v;
         mwb_t <= mma_t;
      end
   end

   // Candidates are scanned lowest priority first so the last match written wins.
   always_comb begin
      sel_hit  = '0;
      sel_stg  = '0;
      sel_lane = '0;
      src_tag  = '0;
      for (int c = 0; c < CONSUMERS; c++) begin
         src_tag = src_preg[c*PREG_W +: PREG_W];
         if (src_valid[c]) begin
            for (int i = MEM_LANES-1; i >= 0; i--) begin
               if (mwb_v[i] && mwb_t[i] == src_tag) begin
                  sel_hit[c]                   = 1'b1;
                  sel_stg[c*2 +: 2]            = STG_MEM_WB;
                  sel_lane[c*LANE_W +: LANE_W] = LANE_W'(i);
               end
            end
            for (int i = INT_LANES-1; i >= 0; i--) begin
               if (iwb_v[i] && iwb_t[i] == src_tag) begin
                  sel_hit[c]                   = 1'b1;
                  sel_stg[c*2 +: 2]            = STG_INT_WB;
                  sel_lane[c*LANE_W +: LANE_W] = LANE_W'(i);
               end
            end
            for (int i = MEM_LANES-1; i >= 0; i--) begin
               if (mma_v[i] && mma_t[i] == src_tag) begin
                  sel_hit[c]                   = 1'b1;
                  sel_stg[c*2 +: 2]            = STG_MEM_MA;
                  sel_lane[c*LANE_W +: LANE_W] = LANE_W'(i);
               end
            end
            for (int i = INT_LANES-1; i >= 0; i--) begin
               if (iex_v[i] && iex_t[i] == src_tag) begin
                  sel_hit[c]                   = 1'b1;
                  sel_stg[c*2 +: 2]            = STG_INT_EX;
                  sel_lane[c*LANE_W +: LANE_W] = LANE_W'(i);
               end
            end
         end
      end
   end

   always_comb begin
      hit_sum = {1'b0, hit_count};
      for (int c = 0; c < CONSUMERS; c++) begin
         hit_sum = hit_sum + (CNT_W+1)'(sel_hit[c]);
      end
   end

   // Carry out of the widened sum means the counter would wrap: pin it at all-ones.
   always_ff @(posedge clk) begin
      if (rst) begin
         hit_count <= '0;
      end else if (!stall && !clear) begin
         hit_count <= hit_sum[CNT_W] ? {CNT_W{1'b1}} : hit_sum[CNT_W-1:0];
      end
   end

endmodule

// File: tb/tb_bypass_select_ctrl.sv
// Bench for bypass_select_ctrl: directed scenarios plus random traffic against a producer-list model.
module tb_bypass_select_ctrl;
   localparam int PW = 7;

   logic        clk = 1'b0;
   logic        rst, stall, clear;
   logic [1:0]  int_dst_valid, mem_dst_valid;
   logic [13:0] int_dst_preg, mem_dst_preg;
   logic [5:0]  src_valid;
   logic [41:0] src_preg;
   logic [5:0]  sel_hit, sel_hit4;
   logic [11:0] sel_stg, sel_stg4;
   logic [5:0]  sel_lane, sel_lane4;
   logic [31:0] hit_count;
   logic [3:0]  hit_count4;

   int checks = 0;
   int failures = 0;

   bypass_select_ctrl dut (
      .clk(clk), .rst(rst), .stall(stall), .clear(clear),
      .int_dst_valid(int_dst_valid), .int_dst_preg(int_dst_preg),
      .mem_dst_valid(mem_dst_valid), .mem_dst_preg(mem_dst_preg),
      .src_valid(src_valid), .src_preg(src_preg),
      .sel_hit(sel_hit), .sel_stg(sel_stg), .sel_lane(sel_lane), .hit_count(hit_count)
   );

   bypass_select_ctrl #(.CNT_W(4)) dut4 (
      .clk(clk), .rst(rst), .stall(stall), .clear(clear),
      .int_dst_valid(int_dst_valid), .int_dst_preg(int_dst_preg),
      .mem_dst_valid(mem_dst_valid), .mem_dst_preg(mem_dst_preg),
      .src_valid(src_valid), .src_preg(src_preg),
      .sel_hit(sel_hit4), .sel_stg(sel_stg4), .sel_lane(sel_lane4), .hit_count(hit_count4)
   );

   always #5 clk = ~clk;

   // Reference: a list of live producers, each with its age (1 = EX/MA, 2 = WB).
   typedef struct {
      bit is_mem;
      int lane;
      int tag;
      int age;
   } prod_t;

   prod_t       q[$];
   longint      mc;
   longint      mc4;

   function automatic void model_expect(input int c, output bit h, output int stg, output int lane);
      int best;
      int rank;
      h = 0; stg = 0; lane = 0; best = 1000;
      if (src_valid[c]) begin
         foreach (q[k]) begin
            if (q[k].tag == int'(src_preg[c*PW +: PW])) begin
               // Priority order: INT_EX, MEM_MA, INT_WB, MEM_WB; lower lane first.
               rank = (q[k].is_mem ? (q[k].age == 1 ? 1 : 3) : (q[k].age == 1 ? 0 : 2)) * 16 + q[k].lane;
               if (rank < best) begin
                  best = rank;
                  h = 1;
                  stg = q[k].is_mem ? (q[k].age == 1 ? 2 : 3) : (q[k].age == 1 ? 0 : 1);
                  lane = q[k].lane;
               end
            end
         end
      end
   endfunction

   function automatic void model_step();
      prod_t nq[$];
      prod_t p;
      int hits;
      bit h;
      int s, l;
      if (rst || clear) begin
         q.delete();
         if (rst) begin
            mc = 0;
            mc4 = 0;
         end
      end else if (!stall) begin
         hits = 0;
         for (int c = 0; c < 6; c++) begin
            model_expect(c, h, s, l);
            hits += int'(h);
         end
         mc = (mc + hits > 64'hFFFF_FFFF) ? 64'hFFFF_FFFF : mc + hits;
         mc4 = (mc4 + hits > 15) ? 15 : mc4 + hits;
         foreach (q[k]) begin
            if (q[k].age < 2) begin
               p = q[k];
               p.age = p.age + 1;
               nq.push_back(p);
            end
         end
         for (int i = 0; i < 2; i++) begin
            if (int_dst_valid[i]) begin
               p.is_mem = 0; p.lane = i; p.tag = int'(int_dst_preg[i*PW +: PW]); p.age = 1;
               nq.push_back(p);
            end
            if (mem_dst_valid[i]) begin
               p.is_mem = 1; p.lane = i; p.tag = int'(mem_dst_preg[i*PW +: PW]); p.age = 1;
               nq.push_back(p);
            end
         end
         q = nq;
      end
   endfunction

   task automatic tick();
      @(posedge clk);
      model_step();
      #1;
   endtask

   task automatic drive_idle();
      stall = 0; clear = 0;
      int_dst_valid = '0; int_dst_preg = '0;
      mem_dst_valid = '0; mem_dst_preg = '0;
      src_valid = '0; src_preg = '0;
   endtask

   task automatic flush();
      drive_idle();
      clear = 1;
      tick();
      clear = 0;
   endtask

   task automatic test_reset();
      drive_idle();
      rst = 1;
      src_valid = 6'h3F;
      tick();
      tick();
      #1;
      checks++;
      if (sel_hit !== 6'h0) begin failures++; $display("FAIL reset_hit got=%h exp=0", sel_hit); end
      checks++;
      if (sel_stg !== 12'h0 || sel_lane !== 6'h0) begin
         failures++; $display("FAIL reset_sel got stg=%h lane=%h exp=0", sel_stg, sel_lane);
      end
      checks++;
      if (hit_count !== 32'd0 || hit_count4 !== 4'd0) begin
         failures++; $display("FAIL reset_count got=%0d/%0d exp=0", hit_count, hit_count4);
      end
      rst = 0;
      drive_idle();
   endtask

   task automatic test_int_latency();
      longint exp_cnt;
      flush();
      int_dst_valid = 2'b10; int_dst_preg[PW +: PW] = 7'h15;
      src_valid = 6'h01; src_preg[0 +: PW] = 7'h15;
      exp_cnt = mc;
      tick();
      int_dst_valid = '0;
      #1;
      checks++;
      if ({sel_hit[0], sel_stg[1:0], sel_lane[0]} !== 4'b1001) begin
         failures++; $display("FAIL int_ex got hit=%b stg=%0d lane=%b exp 1/0/1", sel_hit[0], sel_stg[1:0], sel_lane[0]);
      end
      tick();
      checks++;
      if ({sel_hit[0], sel_stg[1:0], sel_lane[0]} !== 4'b1011) begin
         failures++; $display("FAIL int_wb got hit=%b stg=%0d lane=%b exp 1/1/1", sel_hit[0], sel_stg[1:0], sel_lane[0]);
      end
      tick();
      checks++;
      if (sel_hit[0] !== 1'b0 || sel_stg[1:0] !== 2'd0) begin
         failures++; $display("FAIL int_drop got hit=%b stg=%0d exp 0/0", sel_hit[0], sel_stg[1:0]);
      end
      checks++;
      if (hit_count !== 32'(exp_cnt + 2)) begin
         failures++; $display("FAIL int_count got=%0d exp=%0d", hit_count, exp_cnt + 2);
      end
   endtask

   task automatic test_stall();
      int exp_stg[5] = '{2, 2, 2, 3, 0};
      bit exp_hit[5] = '{1, 1, 1, 1, 0};
      flush();
      mem_dst_valid = 2'b01; mem_dst_preg[0 +: PW] = 7'h22;
      src_valid = 6'h02; src_preg[PW +: PW] = 7'h22;
      tick();
      mem_dst_valid = '0;
      for (int k = 0; k < 5; k++) begin
         stall = (k < 2);
         #1;
         checks++;
         if (sel_hit[1] !== exp_hit[k] || int'(sel_stg[3:2]) != exp_stg[k] || sel_lane[1] !== 1'b0) begin
            failures++;
            $display("FAIL stall_t%0d got hit=%b stg=%0d lane=%b exp hit=%b stg=%0d lane=0",
                     k + 1, sel_hit[1], sel_stg[3:2], sel_lane[1], exp_hit[k], exp_stg[k]);
         end
         tick();
      end
      stall = 0;
   endtask

   task automatic test_priority();
      flush();
      int_dst_valid = 2'b01; int_dst_preg[0 +: PW] = 7'h09;
      mem_dst_valid = 2'b10; mem_dst_preg[PW +: PW] = 7'h09;
      tick();
      int_dst_valid = '0; mem_dst_valid = '0;
      src_valid = 6'h04; src_preg[2*PW +: PW] = 7'h09;
      #1;
      checks++;
      if ({sel_hit[2], sel_stg[5:4], sel_lane[2]} !== 4'b1000) begin
         failures++; $display("FAIL prio_ex_vs_ma got hit=%b stg=%0d lane=%b exp 1/0/0", sel_hit[2], sel_stg[5:4], sel_lane[2]);
      end
      tick();
      checks++;
      if ({sel_hit[2], sel_stg[5:4], sel_lane[2]} !== 4'b1010) begin
         failures++; $display("FAIL prio_wb got hit=%b stg=%0d lane=%b exp 1/1/0", sel_hit[2], sel_stg[5:4], sel_lane[2]);
      end
   endtask

   task automatic test_clear();
      longint exp_cnt;
      flush();
      int_dst_valid = 2'b01; int_dst_preg[0 +: PW] = 7'h30;
      src_valid = 6'h01; src_preg[0 +: PW] = 7'h30;
      tick();
      int_dst_valid = '0;
      clear = 1;
      exp_cnt = mc;
      #1;
      checks++;
      if (sel_hit[0] !== 1'b1) begin failures++; $display("FAIL clear_pre got=%b exp=1", sel_hit[0]); end
      tick();
      clear = 0;
      for (int k = 0; k < 2; k++) begin
         #1;
         checks++;
         if (sel_hit[0] !== 1'b0) begin failures++; $display("FAIL clear_post%0d got=%b exp=0", k, sel_hit[0]); end
         tick();
      end
      checks++;
      if (hit_count !== 32'(exp_cnt)) begin
         failures++; $display("FAIL clear_count got=%0d exp=%0d", hit_count, exp_cnt);
      end
   endtask

   task automatic test_saturation();
      drive_idle();
      rst = 1;
      tick();
      rst = 0;
      int_dst_valid = 2'b01; int_dst_preg[0 +: PW] = 7'h40;
      src_preg = {6{7'h40}};
      tick();
      src_valid = 6'h3F;
      tick();
      tick();
      src_valid = 6'h03;
      tick();
      checks++;
      if (hit_count4 !== 4'd14) begin failures++; $display("FAIL sat_pre got=%0d exp=14", hit_count4); end
      src_valid = 6'h07;
      #1;
      checks++;
      if (sel_hit4 !== 6'h07) begin failures++; $display("FAIL sat_hits got=%h exp=07", sel_hit4); end
      tick();
      checks++;
      if (hit_count4 !== 4'd15) begin failures++; $display("FAIL sat_clamp got=%0d exp=15", hit_count4); end
      src_valid = 6'h3F;
      tick();
      tick();
      checks++;
      if (hit_count4 !== 4'd15) begin failures++; $display("FAIL sat_hold got=%0d exp=15", hit_count4); end
      checks++;
      if (hit_count !== 32'd29) begin failures++; $display("FAIL sat_wide got=%0d exp=29", hit_count); end
      drive_idle();
   endtask

   task automatic test_random();
      logic [5:0]  eh, el;
      logic [11:0] es;
      bit h;
      int s, l;
      int nfail;
      nfail = 0;
      for (int n = 0; n < 400; n++) begin
         rst   = ($urandom_range(0, 59) == 0);
         clear = ($urandom_range(0, 19) == 0);
         stall = ($urandom_range(0, 4) == 0);
         int_dst_valid = 2'($urandom);
         mem_dst_valid = 2'($urandom);
         src_valid     = 6'($urandom);
         for (int i = 0; i < 2; i++) begin
            int_dst_preg[i*PW +: PW] = 7'($urandom_range(0, 7));
            mem_dst_preg[i*PW +: PW] = 7'($urandom_range(0, 7));
         end
         for (int c = 0; c < 6; c++) src_preg[c*PW +: PW] = 7'($urandom_range(0, 7));
         #1;
         for (int c = 0; c < 6; c++) begin
            model_expect(c, h, s, l);
            eh[c] = h; es[c*2 +: 2] = 2'(s); el[c] = l[0];
         end
         checks++;
         if (sel_hit !== eh || sel_stg !== es || sel_lane !== el) begin
            failures++;
            if (nfail++ < 10) $display("FAIL rand_sel cyc=%0d got hit=%h stg=%h lane=%h exp hit=%h stg=%h lane=%h",
                                        n, sel_hit, sel_stg, sel_lane, eh, es, el);
         end
         checks++;
         if (hit_count !== 32'(mc) || hit_count4 !== 4'(mc4)) begin
            failures++;
            if (nfail++ < 10) $display("FAIL rand_count cyc=%0d got=%0d/%0d exp=%0d/%0d", n, hit_count, hit_count4, mc, mc4);
         end
         tick();
      end
      drive_idle();
      rst = 0;
   endtask

   initial begin
      rst = 1;
      mc = 0;
      mc4 = 0;
      drive_idle();
      test_reset();
      test_int_latency();
      test_stall();
      test_priority();
      test_clear();
      test_saturation();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
